// File: rtl/sccomp_run_ctrl.sv
// ============================================================================
// sccomp_run_ctrl -- run/step/breakpoint controller for a single-cycle CPU
//
// Produces a one-cycle CPU clock enable (cpu_en) from a free-running
// divider tick. Supports free run, single step, a single pc breakpoint, and
// a sticky pc-fault halt for pcs that fall outside the instruction memory.
//
// Configuration macro:
//   RUN_CTRL_BKPT_EN  defined   -> breakpoint compare active in RUN
//                     undefined -> bkpt_addr ignored, HALT only via fault
//
// Parameters:
//   DIV        clk_in cycles per enable tick (>= 1)
//   TEXT_BASE  byte address of instruction word 0
//   IMEM_AW    instruction-memory word-address width
//   CNT_W      retired-instruction counter width
//
// Ports:
//   clk_in     in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   run        in   level, request free run
//   step       in   rising edge requests one instruction
//   bkpt_addr  in   breakpoint byte address
//   pc         in   current CPU pc
//   cpu_en     out  CPU clock enable, one clk_in cycle wide
//   imem_addr  out  instruction word address derived from pc
//   pc_fault   out  sticky pc fault, cleared only by reset
//   halted     out  state == HALT
//   state      out  IDLE=00 RUN=01 STEP=10 HALT=11
//   inst_cnt   out  count of cpu_en pulses (wraps)
// ============================================================================
module sccomp_run_ctrl #(
  parameter int          DIV       = 10,
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter int          IMEM_AW   = 11,
  parameter int          CNT_W     = 32
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [31:0]        bkpt_addr,
  input  logic [31:0]        pc,
  output logic               cpu_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               pc_fault,
  output logic               halted,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   inst_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  // A width of at least 1 keeps DIV=1 legal; the counter then sits at 0 and
  // tick is permanently high.
  localparam int                DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
  // Byte size of the instruction memory; one extra bit so IMEM_AW=30 fits.
  localparam logic [32:0]       IMEM_BYTES = 33'(4) << IMEM_AW;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic                step_q;
  logic                step_edge;
  logic                pc_fault_q;
  logic [CNT_W-1:0]    inst_cnt_q;
  logic [31:0]         offset;
  logic                fault;
  logic                bkpt_hit;
  logic                active;

  // --------------------------------------------------------------------------
  // Address map and fault detection (pure combinational on pc)
  // --------------------------------------------------------------------------
  assign offset    = pc - TEXT_BASE;
  assign imem_addr = offset[IMEM_AW+1:2];
  assign fault     = (pc < TEXT_BASE)
                   || ({1'b0, offset} >= IMEM_BYTES)
                   || (pc[1:0] != 2'b00);

`ifdef RUN_CTRL_BKPT_EN
  assign bkpt_hit = (state_q == S_RUN) && (pc == bkpt_addr);
`else
  // The port stays for pin compatibility; fold it into an unused net.
  logic unused_bkpt;
  assign unused_bkpt = ^bkpt_addr;
  assign bkpt_hit    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Divider, step history, fault flag, counter and state register
  // --------------------------------------------------------------------------
  assign tick      = (div_cnt == DIV_LAST);
  assign step_edge = step && !step_q;
  assign active    = (state_q == S_RUN) || (state_q == S_STEP);

  // NOTE: every register here uses non-blocking assignment so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      step_q     <= 1'b0;
      pc_fault_q <= 1'b0;
      inst_cnt_q <= '0;
      state_q    <= S_IDLE;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      step_q     <= step;
      pc_fault_q <= pc_fault_q || (active && fault);
      if (cpu_en) inst_cnt_q <= inst_cnt_q + 1'b1;
      state_q    <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and enable logic
  // --------------------------------------------------------------------------
  // NOTE: defaults are assigned before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run)            state_d = S_RUN;
        else if (step_edge) state_d = S_STEP;
      end
      S_RUN: begin
        cpu_en = tick && !fault && !bkpt_hit;
        if (fault)                state_d = S_HALT;
        else if (!run)            state_d = S_IDLE;
        else if (tick && bkpt_hit) state_d = S_HALT;
      end
      S_STEP: begin
        cpu_en = tick && !fault;
        if (fault)     state_d = S_HALT;
        else if (tick) state_d = S_IDLE;
      end
      S_HALT: begin
        // A faulted controller stays parked until reset.
        if (pc_fault_q)     state_d = S_HALT;
        else if (step_edge) state_d = S_STEP;
        else if (!run)      state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc_fault = pc_fault_q;
  assign halted   = (state_q == S_HALT);
  assign state    = state_q;
  assign inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// ============================================================================
// tb_sccomp_run_ctrl -- scoreboard bench for sccomp_run_ctrl (DIV=4,
// IMEM_AW=11). Scenarios push the expected cpu_en pulses (inst_cnt before
// the pulse and imem word) into a queue; a negedge monitor pops one entry
// per observed pulse. State snapshots use check().
// ============================================================================
module tb_sccomp_run_ctrl;

  localparam int DIV     = 4;
  localparam int IMEM_AW = 11;
  localparam int CNT_W   = 32;

  logic               clk_in = 1'b0;
  logic               reset;
  logic               run;
  logic               step;
  logic [31:0]        bkpt_addr;
  logic [31:0]        pc;
  logic               cpu_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic               pc_fault;
  logic               halted;
  logic [1:0]         state;
  logic [CNT_W-1:0]   inst_cnt;

  typedef struct {
    string       name;
    logic [31:0] cnt;
    logic [31:0] word;
  } pulse_t;

  pulse_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  sccomp_run_ctrl #(
    .DIV(DIV), .TEXT_BASE(32'h0040_0000), .IMEM_AW(IMEM_AW), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .run(run), .step(step),
    .bkpt_addr(bkpt_addr), .pc(pc), .cpu_en(cpu_en), .imem_addr(imem_addr),
    .pc_fault(pc_fault), .halted(halted), .state(state), .inst_cnt(inst_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input string name, input int cnt, input int word);
    pulse_t p;
    p.name = name;
    p.cnt  = cnt;
    p.word = word;
    exp_q.push_back(p);
  endtask

  // Monitor: every enable pulse must match the next queued expectation.
  always @(negedge clk_in) begin
    if (cpu_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got inst_cnt=%0d imem=%0d expected no pulse",
                 inst_cnt, imem_addr);
      end else begin
        pulse_t p;
        p = exp_q.pop_front();
        if (inst_cnt !== p.cnt || 32'(imem_addr) !== p.word) begin
          failures++;
          $display("FAIL %s: got inst_cnt=%0d imem=%0d expected inst_cnt=%0d imem=%0d",
                   p.name, inst_cnt, imem_addr, p.cnt, p.word);
        end
      end
    end
  end

  // Each iteration ends 1ns after a rising edge; with advance set, pc moves
  // by 4 after every cycle that carried a pulse (the CPU executed).
  task automatic run_cycles(input int n, input bit advance);
    for (int i = 0; i < n; i++) begin
      logic en;
      @(negedge clk_in);
      en = cpu_en;
      @(posedge clk_in);
      #1;
      if (advance && en) pc = pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
  endtask

  task automatic fault_case(input string name, input logic [31:0] bad_pc);
    do_reset();
    bkpt_addr = 32'h0040_1000;
    pc  = bad_pc;
    run = 1'b1;
    run_cycles(3, 1'b0);
    check({name, "_pc_fault"}, 32'(pc_fault), 32'd1);
    check({name, "_halted"},   32'(halted),   32'd1);
    check({name, "_inst_cnt"}, inst_cnt,      32'd0);
    // run/step activity must not release a faulted controller.
    run = 1'b0; run_cycles(2, 1'b0);
    step = 1'b1; run_cycles(2, 1'b0);
    step = 1'b0; run = 1'b1; run_cycles(2, 1'b0);
    step = 1'b1; run = 1'b0; run_cycles(5, 1'b0);
    step = 1'b0;
    check({name, "_sticky_state"}, 32'(state), 32'd3);
    check({name, "_sticky_fault"}, 32'(pc_fault), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0;
    bkpt_addr = 32'h0040_1000;
    pc = 32'h0040_0008;
    repeat (2) @(posedge clk_in);
    #1;
    // Reset state; imem_addr keeps tracking pc during reset.
    check("rst_state",    32'(state),    32'd0);
    check("rst_cpu_en",   32'(cpu_en),   32'd0);
    check("rst_halted",   32'(halted),   32'd0);
    check("rst_pc_fault", 32'(pc_fault), 32'd0);
    check("rst_inst_cnt", inst_cnt,      32'd0);
    check("map_word2",    32'(imem_addr), 32'd2);
    pc = 32'h0040_1FFC;
    #1;
    check("map_word7ff",  32'(imem_addr), 32'h7FF);
    reset = 1'b0;

    // run and step together in IDLE: run wins.
    do_reset();
    pc = 32'h0040_0000;
    run = 1'b1; step = 1'b1;
    run_cycles(1, 1'b0);
    check("prio_run_over_step", 32'(state), 32'd1);

    // Free run: one pulse per 4 cycles, first after three edges.
    do_reset();
    pc = 32'h0040_0000;
    for (int i = 0; i < 10; i++) expect_pulse("free_run", i, 0);
    run = 1'b1;
    run_cycles(20, 1'b0);
    check("free_run_cnt_half", inst_cnt, 32'd5);
    run_cycles(20, 1'b0);
    check("free_run_cnt", inst_cnt, 32'd10);
    run = 1'b0;
    run_cycles(2, 1'b0);
    check("free_run_idle", 32'(state), 32'd0);

    // Single step with step held high: exactly one pulse.
    expect_pulse("single_step", 10, 0);
    step = 1'b1;
    run_cycles(20, 1'b0);
    step = 1'b0;
    run_cycles(2, 1'b0);
    check("step_cnt",   inst_cnt,   32'd11);
    check("step_state", 32'(state), 32'd0);

    // Breakpoint at word 4.
    do_reset();
    bkpt_addr = 32'h0040_0010;
    pc = 32'h0040_0000;
    for (int i = 0; i < 4; i++) expect_pulse("bkpt_run", i, i);
`ifdef RUN_CTRL_BKPT_EN
    run = 1'b1;
    run_cycles(24, 1'b1);
    check("bkpt_halted", 32'(halted), 32'd1);
    check("bkpt_cnt",    inst_cnt,    32'd4);
    // Step over: step edge beats run=0 in HALT.
    expect_pulse("bkpt_step_over", 4, 4);
    step = 1'b1; run = 1'b0;
    run_cycles(8, 1'b1);
    step = 1'b0;
    check("step_over_cnt",   inst_cnt,        32'd5);
    check("step_over_word",  32'(imem_addr),  32'd5);
    check("step_over_state", 32'(state),      32'd0);
`else
    expect_pulse("bkpt_off_run", 4, 4);
    expect_pulse("bkpt_off_run", 5, 5);
    run = 1'b1;
    run_cycles(24, 1'b1);
    check("bkpt_off_halted", 32'(halted), 32'd0);
    check("bkpt_off_cnt",    inst_cnt,    32'd6);
    check("bkpt_off_state",  32'(state),  32'd1);
`endif

    // Highest legal word runs normally.
    do_reset();
    bkpt_addr = 32'h0040_1000;
    pc = 32'h0040_1FFC;
    expect_pulse("top_word", 0, 32'h7FF);
    expect_pulse("top_word", 1, 32'h7FF);
    run = 1'b1;
    run_cycles(8, 1'b0);
    check("top_word_fault", 32'(pc_fault), 32'd0);
    check("top_word_cnt",   inst_cnt,      32'd2);

    fault_case("fault_low",   32'h0000_1000);
    fault_case("fault_high",  32'h0040_2000);
    fault_case("fault_align", 32'h0040_0002);

    // Reset in the middle of an enable pulse.
    do_reset();
    pc = 32'h0040_0000;
    for (int i = 0; i < 7; i++) expect_pulse("pre_abort", i, 0);
    run = 1'b1;
    run_cycles(31, 1'b0);
    check("abort_pre_cnt",    inst_cnt,    32'd7);
    check("abort_pre_cpu_en", 32'(cpu_en), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("abort_cpu_en", 32'(cpu_en), 32'd0);
    check("abort_cnt",    inst_cnt,    32'd0);
    check("abort_state",  32'(state),  32'd0);
    run = 1'b0;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    run_cycles(2, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
